reset_clken_sequencer: RTL and testbench

//   Parametrised reset/clock-enable generator for TOPLEVEL fabric logic. Replaces a single

---
 rtl/reset_clken_sequencer.sv | 150 +++++++++++++++
 tb/tb_reset_clken_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reset_clken_sequencer.sv
// Staged per-channel reset release with masked software re-reset
// and a programmable clock-enable strobe.
module reset_clken_sequencer #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 16,
    parameter int DIV_W       = 8
) (
    input  logic             SYSCLK,
    input  logic             NSYSRESET,
    input  logic             sw_rst_req,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [DIV_W-1:0] div,
    output logic [N_CH-1:0]  rst_n_out,
    output logic             clk_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  rst_q, rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zreq_q, zreq_d;
    logic [N_CH-1:0]  lowest;
    logic             rel_go;

    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic             hit_q, hit_d;
    logic             clk_en_q, clk_en_d;

    // Lowest channel still waiting for release.
    always_comb begin
        lowest = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lowest    = '0;
                lowest[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        done_d  = zreq_q;
        zreq_d  = 1'b0;
        rel_go  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sw_rst_req) begin
                    if (|ch_mask) begin
                        state_d = S_ASSERT;
                        pend_d  = ch_mask;
                        busy_d  = 1'b1;
                    end else begin
                        zreq_d = 1'b1;
                    end
                end
            end
            S_ASSERT: begin
                rst_d   = rst_q & ~pend_q;
                cnt_d   = CNT_W'(1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
                    rel_go = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (cnt_q == CNT_W'(STAGE_GAP)) begin
                    rel_go = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Finishing the last pending channel ends the sequence on this edge.
        if (rel_go) begin
            rst_d  = rst_q | lowest;
            pend_d = pend_q & ~lowest;
            cnt_d  = CNT_W'(1);
            if (pend_d == '0) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = S_RELEASE;
            end
        end
    end

    // Extra hit stage keeps the strobe one cycle behind the wrap.
    always_comb begin
        hit_d    = (dcnt_q >= div);
        dcnt_d   = hit_d ? '0 : dcnt_q + DIV_W'(1);
        clk_en_d = hit_q;
    end

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            pend_q   <= '1;
            rst_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            zreq_q   <= 1'b0;
            dcnt_q   <= '0;
            hit_q    <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rst_q    <= rst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zreq_q   <= zreq_d;
            dcnt_q   <= dcnt_d;
            hit_q    <= hit_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign rst_n_out = rst_q;
    assign clk_en    = clk_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reset_clken_sequencer.sv
// Directed bench for reset_clken_sequencer: power-on staging,
// masked re-reset, ignored/zero requests, mid-run reset, divider.
module tb_reset_clken_sequencer;

    logic       clk;
    logic       nrst;
    logic       req;
    logic [3:0] mask;
    logic [7:0] div;
    logic [3:0] rst_n_out;
    logic       clk_en;
    logic       busy;
    logic       done;

    int e;
    int passed;
    int total;

    reset_clken_sequencer #(
        .N_CH(4),
        .HOLD_CYCLES(10),
        .STAGE_GAP(4),
        .CNT_W(16),
        .DIV_W(8)
    ) dut (
        .SYSCLK(clk),
        .NSYSRESET(nrst),
        .sw_rst_req(req),
        .ch_mask(mask),
        .div(div),
        .rst_n_out(rst_n_out),
        .clk_en(clk_en),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s e=%0d obs=%0h exp=%0h", tag, e, obs, exp);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        tick();
        chk("rst_rst_n", 32'(rst_n_out), 32'h0);
        chk("rst_clk_en", 32'(clk_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        nrst = 1'b1;
        e = -1;
    endtask

    // Power-on timing with div=3: bit i rises at 10+4i, done at 22,
    // clk_en high on edges 4,8,12,...
    task automatic por_check(input int last, input int req_edge);
        logic [3:0] exp_rst;
        for (int k = 0; k <= last; k++) begin
            tick();
            if (e == req_edge - 1) begin
                req  = 1'b1;
                mask = 4'hF;
            end
            if (e == req_edge) begin
                req  = 1'b0;
                mask = 4'h0;
            end
            for (int i = 0; i < 4; i++) begin
                exp_rst[i] = (e >= 10 + 4 * i);
            end
            chk("por_rst_n", 32'(rst_n_out), 32'(exp_rst));
            chk("por_done", 32'(done), 32'(e == 22));
            chk("por_busy", 32'(busy), 32'(e < 22));
            chk("por_clk_en", 32'(clk_en), 32'((e >= 4) && (e % 4 == 0)));
        end
    endtask

    initial begin
        logic [3:0] exp_rst;
        passed = 0;
        total  = 0;
        e      = -1;
        nrst   = 1'b0;
        req    = 1'b0;
        mask   = 4'h0;
        div    = 8'd3;

        do_reset();
        por_check(25, -1);

        // Masked re-reset of channels 1 and 3; mask change after
        // sampling must not matter.
        req  = 1'b1;
        mask = 4'b1010;
        tick();
        req  = 1'b0;
        mask = 4'hF;
        chk("sw_r_rst_n", 32'(rst_n_out), 32'hF);
        chk("sw_r_busy", 32'(busy), 32'h1);
        chk("sw_r_done", 32'(done), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_rst    = 4'b0101;
            exp_rst[1] = (k >= 11);
            exp_rst[3] = (k >= 15);
            chk("sw_rst_n", 32'(rst_n_out), 32'(exp_rst));
            chk("sw_done", 32'(done), 32'(k == 15));
            chk("sw_busy", 32'(busy), 32'(k < 15));
        end

        // Zero mask: only a delayed done pulse.
        req  = 1'b1;
        mask = 4'h0;
        tick();
        req = 1'b0;
        chk("z0_rst_n", 32'(rst_n_out), 32'hF);
        chk("z0_busy", 32'(busy), 32'h0);
        chk("z0_done", 32'(done), 32'h0);
        tick();
        chk("z1_rst_n", 32'(rst_n_out), 32'hF);
        chk("z1_busy", 32'(busy), 32'h0);
        chk("z1_done", 32'(done), 32'h1);
        tick();
        chk("z2_done", 32'(done), 32'h0);
        chk("z2_busy", 32'(busy), 32'h0);

        // Request while busy at edge 12 is dropped.
        do_reset();
        por_check(25, 12);

        // Reset during RELEASE restarts the power-on sequence.
        do_reset();
        por_check(15, -1);
        do_reset();
        por_check(25, -1);

        // Divider switched to 0: strobe stays high after the wrap.
        div = 8'd0;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("div0_clk_en", 32'(clk_en), 32'h1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
